// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared definitions for the instruction fetch queue that sits between the
// IF and ID stages:
//   - default geometry of the queue,
//   - the {pc, inst} entry packing (pc in the MSBs, as on the if_to_id bus),
//   - a helper that computes the packed entry width for any pc/inst widths,
//   - the push/pop operation encoding used by the pointer/count logic.
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

    localparam int FQ_DEPTH_DEF  = 4;
    localparam int FQ_PC_W_DEF   = 32;
    localparam int FQ_INST_W_DEF = 32;
    localparam int FQ_ENTRY_WD   = FQ_PC_W_DEF + FQ_INST_W_DEF;

    // Default-width entry view; pc occupies the upper bits of the packed word.
    typedef struct packed {
        logic [FQ_PC_W_DEF-1:0]   pc;
        logic [FQ_INST_W_DEF-1:0] inst;
    } fq_entry_t;

    // One-cycle queue operation: {push, pop}.
    typedef enum logic [1:0] {
        FQ_OP_IDLE = 2'b00,
        FQ_OP_POP  = 2'b01,
        FQ_OP_PUSH = 2'b10,
        FQ_OP_BOTH = 2'b11
    } fq_op_e;

    // Packed entry width for a queue built with arbitrary field widths.
    function automatic int fq_entry_wd(input int pc_w, input int inst_w);
        return pc_w + inst_w;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_chk.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_chk
// Property checker bound into the fetch queue. Occupancy must never exceed
// DEPTH, and the queue can never look both full and empty.
// Ports:
//   clk, rst - queue clock and synchronous reset
//   count    - registered occupancy
//   full     - occupancy flag
//   empty    - occupancy flag
// -----------------------------------------------------------------------------
module inst_fetch_queue_chk #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    input logic [$clog2(DEPTH):0]   count,
    input logic                     full,
    input logic                     empty
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    a_count_le_depth : assert property (
        @(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH)
    );

    a_not_full_and_empty : assert property (
        @(posedge clk) disable iff (rst) !(full && empty)
    );

endmodule

// File: rtl/inst_fetch_queue_fq_ram.sv
// -----------------------------------------------------------------------------
// fq_ram
// DEPTH x WIDTH storage for the fetch queue: one synchronous write port and
// one asynchronous read port. The array is deliberately not reset so that it
// maps onto distributed/LUT RAM.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (combinational read)
//   rdata_o  - read data
// -----------------------------------------------------------------------------
module fq_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// FIFO of {pc, inst} pairs between IF and ID. Generalises ID's single-word
// stall capture to DEPTH entries with valid/ready handshakes on both sides.
// A taken branch (flush) discards everything, including any push/pop in the
// same cycle. almost_full gives IF early warning so that a fetch already in
// flight in the 1-cycle SRAM can still be absorbed.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   flush        - branch taken; empties the queue
//   in_valid     - IF presents in_pc/in_inst
//   in_pc        - pc of fetched instruction
//   in_inst      - instruction word for in_pc
//   in_ready     - queue can accept a push (= !full)
//   almost_full  - count >= AF_LEVEL
//   out_valid    - head entry present (= !empty)
//   out_pc       - head pc, 0 when empty
//   out_inst     - head instruction, 0 when empty (ID decodes a bubble)
//   out_ready    - ID consumes the head
//   count        - current occupancy
//   full, empty  - occupancy flags
// -----------------------------------------------------------------------------
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH    = FQ_DEPTH_DEF,
    parameter int PC_W     = FQ_PC_W_DEF,
    parameter int INST_W   = FQ_INST_W_DEF,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     almost_full,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = fq_entry_wd(PC_W, INST_W);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    fq_op_e             op_s;
    logic [ENTRY_W-1:0] wr_data_s;
    logic [ENTRY_W-1:0] rd_data_s;

    // Flags come only from registered occupancy, so in_ready never depends
    // on out_ready and there is no input-to-output combinational path.
    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Flush overrides both handshakes; a push into a full queue is dropped.
    assign push_s = in_valid & ~full_s & ~flush;
    assign pop_s  = ~empty_s & out_ready & ~flush;
    assign op_s   = fq_op_e'({push_s, pop_s});

    // pc in the upper bits, matching the if_to_id bus packing.
    assign wr_data_s = {in_pc, in_inst};

    fq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fq_ram (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data_s)
    );

    // Next-state for pointers and occupancy; pointers wrap at DEPTH naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            case (op_s)
                FQ_OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                FQ_OP_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                FQ_OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: begin
                    wr_ptr_d = wr_ptr_q;
                    rd_ptr_d = rd_ptr_q;
                    count_d  = count_q;
                end
            endcase
        end
    end

    // Pointer/occupancy state; reset wins over flush and drops all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is an asynchronous read of the RAM, forced to zero when empty so
    // that stale storage never reaches ID. While out_ready is low and no
    // flush occurs rd_ptr holds and the head word is stable.
    assign out_pc   = empty_s ? {PC_W{1'b0}}   : rd_data_s[ENTRY_W-1 -: PC_W];
    assign out_inst = empty_s ? {INST_W{1'b0}} : rd_data_s[INST_W-1:0];

    assign out_valid   = ~empty_s;
    assign in_ready    = ~full_s;
    assign full        = full_s;
    assign empty       = empty_s;
    assign count       = count_q;
    assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

    inst_fetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .count (count_q),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed steps from the test plan followed by a randomized phase. Expected
// outputs come from a queue-based reference model of the FIFO rules.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam int DEPTH    = 4;
    localparam int PC_W     = 32;
    localparam int INST_W   = 32;
    localparam int AF_LEVEL = DEPTH - 1;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int EW       = PC_W + INST_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              almost_full;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .almost_full (almost_full),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    int checks  = 0;
    int errors  = 0;
    int dropped = 0;

    // Reference model: contents of the queue, head at index 0, {pc, inst}.
    logic [EW-1:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [EW-1:0] h;
        n = mq.size();
        h = (n > 0) ? mq[0] : {EW{1'b0}};
        chk({tag, ".count"},    64'(count),       64'(n));
        chk({tag, ".empty"},    64'(empty),       64'(n == 0));
        chk({tag, ".full"},     64'(full),        64'(n == DEPTH));
        chk({tag, ".in_ready"}, 64'(in_ready),    64'(n < DEPTH));
        chk({tag, ".af"},       64'(almost_full), 64'(n >= AF_LEVEL));
        chk({tag, ".ovalid"},   64'(out_valid),   64'(n > 0));
        chk({tag, ".out_pc"},   64'(out_pc),      64'(h[EW-1:INST_W]));
        chk({tag, ".out_inst"}, 64'(out_inst),    64'(h[INST_W-1:0]));
    endtask

    // One clock: drive inputs, advance one edge, update the model, compare.
    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] ins,
                        input logic ordy, input logic fl, input logic r, input string tag);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = ins;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        do_push = v && (mq.size() < DEPTH) && !fl;
        do_pop  = (mq.size() > 0) && ordy && !fl;
        if (v && mq.size() == DEPTH && !r) dropped++;
        @(posedge clk);
        #1;
        if (r || fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({pc, ins});
        end
        check_all(tag);
    endtask

    logic [PC_W-1:0]   held_pc;
    logic [INST_W-1:0] held_inst;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

        // Reset
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "rst0");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "rst1");
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.out_pc", 64'(out_pc), 64'd0);

        // Two pushes with out_ready=1, in-order delivery, drains to 0
        step(1'b1, 32'hBFC00000, 32'h3C011234, 1'b1, 1'b0, 1'b0, "t1.p0");
        chk("t1.head0", 64'(out_pc), 64'hBFC00000);
        step(1'b1, 32'hBFC00004, 32'h34210001, 1'b1, 1'b0, 1'b0, "t1.p1");
        chk("t1.head1", 64'(out_inst), 64'h34210001);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t1.drain");
        chk("t1.count0", 64'(count), 64'd0);

        // Five pushes with out_ready=0: fifth dropped
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'hBFC00010 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0, "t2.push");
            if (i == 2) chk("t2.af3", 64'(almost_full), 64'd1);
            if (i == 3) chk("t2.full4", 64'(full), 64'd1);
        end
        chk("t2.count4", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2.drain_pc", 64'(out_pc), 64'(32'hBFC00010 + 32'(4 * i)));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t2.drain");
        end

        // Full queue, push+pop together: pop only, push next cycle; wraps pointers
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'hBFC00040 + 32'(4 * i), 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b0, "t3.fill");
        step(1'b1, 32'hBFC00050, 32'h2004, 1'b1, 1'b0, 1'b0, "t3.both");
        chk("t3.count3", 64'(count), 64'd3);
        step(1'b1, 32'hBFC00050, 32'h2004, 1'b0, 1'b0, 1'b0, "t3.push");
        chk("t3.count4", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t3.drain");

        // Flush with 3 entries and concurrent push/pop
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hBFC00080 + 32'(4 * i), 32'h3000 + 32'(i), 1'b0, 1'b0, 1'b0, "t4.fill");
        step(1'b1, 32'hBFC000F0, 32'h3FFF, 1'b1, 1'b1, 1'b0, "t4.flush");
        chk("t4.empty", 64'(empty), 64'd1);
        chk("t4.inst0", 64'(out_inst), 64'd0);
        step(1'b1, 32'hBFC00100, 32'h24020001, 1'b0, 1'b0, 1'b0, "t4.push");
        chk("t4.head", 64'(out_pc), 64'hBFC00100);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t4.pop");

        // Stall hold
        step(1'b1, 32'hBFC00008, 32'h8C430000, 1'b0, 1'b0, 1'b0, "t5.head");
        held_pc = out_pc;
        held_inst = out_inst;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'hBFC0000C + 32'(4 * i), 32'h4000 + 32'(i), 1'b0, 1'b0, 1'b0, "t5.stall");
            chk("t5.hold_pc", 64'(out_pc), 64'(held_pc));
            chk("t5.hold_inst", 64'(out_inst), 64'(held_inst));
        end
        chk("t5.rel_inst", 64'(out_inst), 64'h8C430000);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t5.drain");

        // Reset mid-stream with 2 entries
        step(1'b1, 32'hBFC00200, 32'h5000, 1'b0, 1'b0, 1'b0, "t6.p0");
        step(1'b1, 32'hBFC00204, 32'h5001, 1'b0, 1'b0, 1'b0, "t6.p1");
        step(1'b1, 32'hBFC00208, 32'h5002, 1'b1, 1'b0, 1'b1, "t6.rst");
        chk("t6.rst_count", 64'(count), 64'd0);
        step(1'b1, 32'hBFC00300, 32'h6000, 1'b0, 1'b0, 1'b0, "t6.post_p");
        chk("t6.post_head", 64'(out_pc), 64'hBFC00300);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "t6.post_pop");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0,
                 ($urandom % 20) == 0, ($urandom % 64) == 0, "rand");
        end

        $display("note: %0d pushes offered while full were ignored", dropped);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
